// File: rtl/mult_rr_scheduler.sv
// mult_rr_scheduler: round-robin front end that shares one
// start/done multiplier, with a watchdog on the done pulse.
module mult_rr_scheduler #(
  parameter int N       = 4,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*N-1:0]        req_a,
  input  logic [NREQ*N-1:0]        req_b,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [2*N-1:0]           rsp_product,
  output logic                     rsp_error,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic                     mul_start,
  output logic [N-1:0]             mul_a,
  output logic [N-1:0]             mul_b,
  input  logic                     mul_done,
  input  logic [2*N-1:0]           mul_product
);

  localparam int IW = $clog2(NREQ);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] win;
  logic          any;
  logic [IW:0]   idx;
  logic [WW-1:0] wd;

  // First requester at or after ptr, wrapping modulo NREQ
  always_comb begin
    win = '0;
    any = 1'b0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + (IW+1)'(k);
      if (idx >= (IW+1)'(NREQ))
        idx = idx - (IW+1)'(NREQ);
      if (!any && req_valid[idx[IW-1:0]]) begin
        win = idx[IW-1:0];
        any = 1'b1;
      end
    end
  end

  // Accept is offered only while idle, one-hot on the winner
  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && any)
      req_ready[win] = 1'b1;
  end

  // Operation sequencer with registered outputs and watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ptr         <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      mul_start   <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      rsp_valid   <= '0;
      rsp_product <= '0;
      rsp_error   <= 1'b0;
      wd          <= '0;
    end else begin
      mul_start <= 1'b0;
      rsp_valid <= '0;
      unique case (state)
        S_IDLE: begin
          if (any) begin
            mul_a     <= req_a[win*N +: N];
            mul_b     <= req_b[win*N +: N];
            grant_id  <= win;
            mul_start <= 1'b1;
            busy      <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wd    <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (mul_done) begin
            rsp_product         <= mul_product;
            rsp_error           <= 1'b0;
            rsp_valid[grant_id] <= 1'b1;
            state               <= S_RESP;
          end else if (wd == WW'(TIMEOUT - 1)) begin
            rsp_product         <= '0;
            rsp_error           <= 1'b1;
            rsp_valid[grant_id] <= 1'b1;
            state               <= S_RESP;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_RESP: begin
          if (grant_id == IW'(NREQ - 1))
            ptr <= '0;
          else
            ptr <= grant_id + 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// tb_mult_rr_scheduler: random and directed traffic against a
// transaction-level round-robin model with a 5-cycle multiplier.
module tb_mult_rr_scheduler;

  localparam int N       = 4;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;
  localparam int IW      = 2;
  localparam int PW      = 2 * N;
  localparam int LAT     = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   rsp_valid;
  logic [PW-1:0]     rsp_product;
  logic              rsp_error;
  logic [IW-1:0]     grant_id;
  logic              busy;
  logic              mul_start;
  logic [N-1:0]      mul_a;
  logic [N-1:0]      mul_b;
  logic              mul_done;
  logic [PW-1:0]     mul_product;

  always #5 clk = ~clk;

  mult_rr_scheduler #(
    .N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_product(rsp_product),
    .rsp_error(rsp_error), .grant_id(grant_id),
    .busy(busy), .mul_start(mul_start),
    .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_product(mul_product)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  bit m_busy = 0;
  int m_ptr = 0;
  int m_port = 0;
  int m_a = 0;
  int m_b = 0;
  int acc_cyc = 0;
  int done_cyc = 0;
  bit done_seen = 0;
  int n_acc = 0;
  int n_rsp = 0;
  int last_prod = 0;
  int last_err = 0;
  int grant_q[$];

  bit rand_mode = 0;
  bit no_done = 0;
  bit spur = 0;
  int mcnt = 0;
  int ma = 0;
  int mb = 0;
  logic [NREQ-1:0] xfer;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] rr_pick(
      input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (p + k) % NREQ;
      if (v[j]) return NREQ'(1) << j;
    end
    return '0;
  endfunction

  function automatic int oh2i(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++)
      if (v[i]) return i;
    return 0;
  endfunction

  // Reference model: round-robin pick, one op in flight, timing rules
  always @(negedge clk) begin : mon
    logic [NREQ-1:0] er;
    logic [NREQ-1:0] ev;
    bit st;
    bit rn;
    cyc++;
    if (!rst_n) begin
      m_busy = 0;
      m_ptr  = 0;
    end else begin
      er = m_busy ? '0 : rr_pick(req_valid, m_ptr);
      chk("req_ready", req_ready, er);
      chk("busy", busy, m_busy);
      st = m_busy && (cyc == acc_cyc + 1);
      chk("mul_start", mul_start, st);
      if (m_busy) chk("grant_id", grant_id, m_port);
      if (st) begin
        chk("mul_a", mul_a, m_a);
        chk("mul_b", mul_b, m_b);
      end
      if (m_busy && !done_seen && mul_done &&
          cyc >= acc_cyc + 2 && cyc <= acc_cyc + 1 + TIMEOUT) begin
        done_seen = 1;
        done_cyc  = cyc;
      end
      rn = m_busy && (done_seen ? (cyc == done_cyc + 1)
                                : (cyc == acc_cyc + 2 + TIMEOUT));
      ev = rn ? (NREQ'(1) << m_port) : '0;
      chk("rsp_valid", rsp_valid, ev);
      if (rn) begin
        chk("rsp_product", rsp_product, done_seen ? m_a * m_b : 0);
        chk("rsp_error", rsp_error, !done_seen);
        last_prod = rsp_product;
        last_err  = rsp_error;
        n_rsp++;
        m_busy = 0;
        m_ptr  = (m_port + 1) % NREQ;
      end else if (er != 0) begin
        m_busy    = 1;
        m_port    = oh2i(er);
        acc_cyc   = cyc;
        m_a       = req_a[m_port*N +: N];
        m_b       = req_b[m_port*N +: N];
        done_seen = 0;
        n_acc++;
        grant_q.push_back(m_port);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    xfer = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (xfer[i]) req_valid[i] = 1'b0;
    mul_done = 1'b0;
    if (!rst_n) begin
      mcnt = 0;
    end else begin
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0 && !no_done) begin
          mul_done    = 1'b1;
          mul_product = PW'(ma * mb);
        end
      end
      if (mul_start) begin
        mcnt = LAT;
        ma   = mul_a;
        mb   = mul_b;
      end
      if (spur && !m_busy && mcnt == 0) begin
        mul_done    = 1'b1;
        mul_product = 8'hAB;
      end
    end
    if (rand_mode) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && !xfer[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req_valid[i]     = 1'b1;
            req_a[i*N +: N]  = N'($urandom);
            req_b[i*N +: N]  = N'($urandom);
          end
        end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic req(input int p, input int a, input int b);
    req_valid[p]    = 1'b1;
    req_a[p*N +: N] = N'(a);
    req_b[p*N +: N] = N'(b);
  endtask

  task automatic drain(input int limit);
    int k;
    k = 0;
    while ((req_valid != 0 || m_busy) && k < limit) begin
      step();
      k++;
    end
    chk("drain_bound", (k < limit), 1);
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_product"}, rsp_product, 0);
    chk({tag, "_rsp_error"}, rsp_error, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mul_start"}, mul_start, 0);
    chk({tag, "_mul_a"}, mul_a, 0);
    chk({tag, "_mul_b"}, mul_b, 0);
  endtask

  initial begin : guard
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end

  initial begin : main
    int q0;
    int k;
    int ord[5];
    int nbefore;
    rst_n       = 1'b0;
    req_valid   = '0;
    req_a       = '0;
    req_b       = '0;
    mul_done    = 1'b0;
    mul_product = '0;
    @(negedge clk);
    chk_zero_outs("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // all four held: grant order 0,1,2,3 then 0 again
    q0 = grant_q.size();
    for (int p = 0; p < NREQ; p++) req(p, p + 1, p + 9);
    k = 0;
    while (n_acc == 0 && k < 20) begin
      step();
      k++;
    end
    req(0, 13, 11);
    drain(200);
    ord = '{0, 1, 2, 3, 0};
    chk("order_len", grant_q.size() - q0, 5);
    for (int i = 0; i < 5; i++)
      if (q0 + i < grant_q.size())
        chk("order", grant_q[q0 + i], ord[i]);

    // single request 3*5
    req(0, 3, 5);
    drain(50);
    chk("t1_prod", last_prod, 15);
    chk("t1_err", last_err, 0);
    chk("t1_port", grant_q[$], 0);

    // wrap-around: ptr=2 after port 1, then 0 before 1
    req(1, 2, 2);
    drain(50);
    q0 = grant_q.size();
    req(0, 1, 1);
    req(1, 3, 3);
    drain(100);
    if (grant_q.size() >= q0 + 2) begin
      chk("wrap0", grant_q[q0], 0);
      chk("wrap1", grant_q[q0 + 1], 1);
    end else begin
      chk("wrap_len", grant_q.size() - q0, 2);
    end

    // full-width product
    req(2, 15, 15);
    drain(50);
    chk("t4_prod", last_prod, 225);

    // random traffic
    nbefore = n_rsp;
    rand_mode = 1;
    repeat (600) step();
    rand_mode = 0;
    drain(400);
    chk("rand_activity", (n_rsp - nbefore) > 20, 1);

    // watchdog
    no_done = 1;
    req(3, 7, 9);
    drain(TIMEOUT + 20);
    chk("t5_err", last_err, 1);
    chk("t5_prod", last_prod, 0);
    no_done = 0;
    req(3, 2, 3);
    drain(50);
    chk("t5_next_err", last_err, 0);
    chk("t5_next_prod", last_prod, 6);

    // spurious done while idle
    spur = 1;
    repeat (4) step();
    spur = 0;
    chk("spur_busy", busy, 0);
    req(1, 6, 7);
    drain(50);
    chk("spur_prod", last_prod, 42);

    // reset in the middle of WAIT
    req(2, 5, 6);
    k = 0;
    while (!(m_busy && cyc >= acc_cyc + 4) && k < 20) begin
      step();
      k++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero_outs("midrst");
    step();
    rst_n = 1'b1;
    q0 = grant_q.size();
    req(3, 4, 4);
    req(0, 2, 5);
    drain(100);
    if (grant_q.size() >= q0 + 2) begin
      chk("rst_ptr0", grant_q[q0], 0);
      chk("rst_ptr1", grant_q[q0 + 1], 3);
    end else begin
      chk("rst_len", grant_q.size() - q0, 2);
    end
    chk("rst_prod", last_prod, 16);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
